// File: rtl/fix_session_pkg.sv
// fix_session_pkg: shared state, rx result and event encodings for the FIX session tracker.
package fix_session_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, TESTREQ_SENT} state_t;
    typedef enum logic [2:0] {OK, GAP, DUP, LOW, NOT_ACTIVE} rx_code_t;
    typedef enum logic [1:0] {NONE, HEARTBEAT, TESTREQ, TIMEOUT} evt_t;
endpackage

// File: rtl/fix_event_arbiter.sv
// fix_event_arbiter: round-robin over hosts, TIMEOUT > TESTREQ > HEARTBEAT within a host, valid/ready output register.
module fix_event_arbiter
    import fix_session_pkg::*;
#(
    parameter int HOST_ADDR_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [2**HOST_ADDR_WIDTH-1:0][2:0]    pend,
    input  logic                                  ready,
    output logic                                  valid,
    output logic [HOST_ADDR_WIDTH-1:0]            host,
    output logic [1:0]                            kind
);
    localparam int N_HOST = 2 ** HOST_ADDR_WIDTH;
    logic [HOST_ADDR_WIDTH-1:0] ptr, h, gnt_host;
    logic found, held;
    evt_t gnt_kind;
    always_comb begin
        found = 1'b0;
        gnt_host = ptr;
        gnt_kind = NONE;
        h = ptr;
        for (int k = 0; k < N_HOST; k++) begin
            h = ptr + HOST_ADDR_WIDTH'(k);
            if (!found && |pend[h]) begin
                found = 1'b1;
                gnt_host = h;
                gnt_kind = pend[h][2] ? TIMEOUT : pend[h][1] ? TESTREQ : HEARTBEAT;
            end
        end
        held = kind == TIMEOUT ? pend[host][2] : kind == TESTREQ ? pend[host][1] : pend[host][0];
    end
    // a presented event whose flag vanished (host closed/reopened) is withdrawn
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            host <= '0;
            kind <= '0;
            ptr <= '0;
        end else if (!valid || ready) begin
            valid <= found;
            if (found) begin
                host <= gnt_host;
                kind <= gnt_kind;
                ptr <= gnt_host + 1'b1;
            end
        end else if (!held) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fix_session_tracker.sv
// fix_session_tracker: per-host FIX session state, MsgSeqNum tracking and heartbeat/test-request timers.
module fix_session_tracker
    import fix_session_pkg::*;
#(
    parameter int HOST_ADDR_WIDTH = 2,
    parameter int SEQ_WIDTH = 16,
    parameter int HB_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_i,
    input  logic [HB_WIDTH-1:0]        hb_interval_i,
    input  logic                       open_i,
    input  logic [HOST_ADDR_WIDTH-1:0] open_host_i,
    input  logic                       close_i,
    input  logic [HOST_ADDR_WIDTH-1:0] close_host_i,
    input  logic                       rx_valid_i,
    input  logic [HOST_ADDR_WIDTH-1:0] rx_host_i,
    input  logic [SEQ_WIDTH-1:0]       rx_seq_i,
    input  logic                       rx_posdup_i,
    input  logic                       rx_gapfill_i,
    output logic                       rx_done_o,
    output logic [2:0]                 rx_code_o,
    output logic [SEQ_WIDTH-1:0]       rx_expected_o,
    input  logic                       tx_req_i,
    input  logic [HOST_ADDR_WIDTH-1:0] tx_host_i,
    output logic                       tx_ack_o,
    output logic [SEQ_WIDTH-1:0]       tx_seq_o,
    output logic                       evt_valid_o,
    output logic [HOST_ADDR_WIDTH-1:0] evt_host_o,
    output logic [1:0]                 evt_type_o,
    input  logic                       evt_ready_i
);
    localparam int N_HOST = 2 ** HOST_ADDR_WIDTH;
    state_t st_q [N_HOST];
    state_t st_d [N_HOST];
    logic [SEQ_WIDTH-1:0] exp_q [N_HOST];
    logic [SEQ_WIDTH-1:0] exp_d [N_HOST];
    logic [SEQ_WIDTH-1:0] ntx_q [N_HOST];
    logic [SEQ_WIDTH-1:0] ntx_d [N_HOST];
    logic [HB_WIDTH-1:0] rxi_q [N_HOST];
    logic [HB_WIDTH-1:0] rxi_d [N_HOST];
    logic [HB_WIDTH-1:0] txi_q [N_HOST];
    logic [HB_WIDTH-1:0] txi_d [N_HOST];
    logic [N_HOST-1:0][2:0] pend_q, pend_d;
    logic rx_blk, rx_upd, tx_ok;
    rx_code_t rx_code;
    logic [SEQ_WIDTH-1:0] rx_exp, rx_new, tx_seq;

    function automatic logic [SEQ_WIDTH-1:0] seq_inc(input logic [SEQ_WIDTH-1:0] s);
        return (&s) ? SEQ_WIDTH'(1) : s + SEQ_WIDTH'(1);
    endfunction

    function automatic logic [HB_WIDTH-1:0] sat_inc(input logic [HB_WIDTH-1:0] t);
        return (&t) ? t : t + HB_WIDTH'(1);
    endfunction

    // open/close on the addressed host pre-empt the rx check and tx grant
    always_comb begin
        rx_exp = exp_q[rx_host_i];
        rx_blk = (open_i && open_host_i == rx_host_i) || (close_i && close_host_i == rx_host_i)
                 || st_q[rx_host_i] == IDLE;
        rx_new = rx_exp;
        rx_upd = 1'b0;
        if (rx_blk) begin
            rx_code = NOT_ACTIVE;
        end else if (rx_gapfill_i) begin
            rx_upd = rx_seq_i >= rx_exp;
            rx_code = rx_upd ? OK : LOW;
            rx_new = rx_seq_i;
        end else if (rx_seq_i == rx_exp) begin
            rx_code = OK;
            rx_upd = 1'b1;
            rx_new = seq_inc(rx_exp);
        end else begin
            rx_code = rx_seq_i > rx_exp ? GAP : rx_posdup_i ? DUP : LOW;
        end
        tx_ok = !(open_i && open_host_i == tx_host_i) && !(close_i && close_host_i == tx_host_i)
                && st_q[tx_host_i] == ACTIVE;
        tx_seq = tx_ok ? ntx_q[tx_host_i] : '0;
    end

    always_comb begin
        pend_d = pend_q;
        if (evt_valid_o && evt_ready_i)
            pend_d[evt_host_o][evt_type_o - 2'd1] = 1'b0;
        for (int h = 0; h < N_HOST; h++) begin
            logic op, cl, rxh, txh, run;
            logic [HB_WIDTH-1:0] ri, ti;
            op = open_i && open_host_i == HOST_ADDR_WIDTH'(h);
            cl = close_i && close_host_i == HOST_ADDR_WIDTH'(h);
            rxh = rx_valid_i && rx_host_i == HOST_ADDR_WIDTH'(h) && !rx_blk;
            txh = tx_req_i && tx_host_i == HOST_ADDR_WIDTH'(h) && tx_ok;
            run = tick_i && hb_interval_i != '0 && st_q[h] != IDLE;
            ri = sat_inc(rxi_q[h]);
            ti = sat_inc(txi_q[h]);
            st_d[h] = st_q[h];
            exp_d[h] = exp_q[h];
            ntx_d[h] = ntx_q[h];
            rxi_d[h] = rxi_q[h];
            txi_d[h] = txi_q[h];
            if (rxh) begin
                rxi_d[h] = '0;
                st_d[h] = ACTIVE;
                if (rx_upd) exp_d[h] = rx_new;
            end else if (run) begin
                rxi_d[h] = ri;
                if (ri >= hb_interval_i) begin
                    rxi_d[h] = '0;
                    st_d[h] = st_q[h] == ACTIVE ? TESTREQ_SENT : IDLE;
                    pend_d[h][st_q[h] == ACTIVE ? 1 : 2] = 1'b1;
                end
            end
            if (txh) begin
                txi_d[h] = '0;
                ntx_d[h] = seq_inc(ntx_q[h]);
            end else if (run) begin
                txi_d[h] = ti;
                if (ti >= hb_interval_i) begin
                    txi_d[h] = '0;
                    pend_d[h][0] = 1'b1;
                end
            end
            if (op || cl) pend_d[h] = '0;
            if (cl) begin
                st_d[h] = IDLE;
            end else if (op) begin
                st_d[h] = ACTIVE;
                exp_d[h] = SEQ_WIDTH'(1);
                ntx_d[h] = SEQ_WIDTH'(1);
                rxi_d[h] = '0;
                txi_d[h] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < N_HOST; h++) begin
                st_q[h] <= IDLE;
                exp_q[h] <= '0;
                ntx_q[h] <= '0;
                rxi_q[h] <= '0;
                txi_q[h] <= '0;
            end
            pend_q <= '0;
            rx_done_o <= 1'b0;
            rx_code_o <= '0;
            rx_expected_o <= '0;
            tx_ack_o <= 1'b0;
            tx_seq_o <= '0;
        end else begin
            st_q <= st_d;
            exp_q <= exp_d;
            ntx_q <= ntx_d;
            rxi_q <= rxi_d;
            txi_q <= txi_d;
            pend_q <= pend_d;
            rx_done_o <= rx_valid_i;
            tx_ack_o <= tx_req_i;
            if (rx_valid_i) begin
                rx_code_o <= rx_code;
                rx_expected_o <= rx_exp;
            end
            if (tx_req_i) tx_seq_o <= tx_seq;
        end
    end

    fix_event_arbiter #(.HOST_ADDR_WIDTH(HOST_ADDR_WIDTH)) u_arb (
        .clk(clk),
        .rst(rst),
        .pend(pend_d),
        .ready(evt_ready_i),
        .valid(evt_valid_o),
        .host(evt_host_o),
        .kind(evt_type_o)
    );
endmodule

// File: tb/tb_fix_session_tracker.sv
// tb_fix_session_tracker: directed vectors with hand-computed expectations for fix_session_tracker.
module tb_fix_session_tracker;
    logic clk = 1'b0, rst = 1'b1;
    logic tick_i = 1'b0;
    logic [7:0] hb_interval_i = '0;
    logic open_i = 1'b0, close_i = 1'b0;
    logic [1:0] open_host_i = '0, close_host_i = '0;
    logic rx_valid_i = 1'b0, rx_posdup_i = 1'b0, rx_gapfill_i = 1'b0;
    logic [1:0] rx_host_i = '0;
    logic [15:0] rx_seq_i = '0;
    logic rx_done_o;
    logic [2:0] rx_code_o;
    logic [15:0] rx_expected_o;
    logic tx_req_i = 1'b0;
    logic [1:0] tx_host_i = '0;
    logic tx_ack_o;
    logic [15:0] tx_seq_o;
    logic evt_valid_o;
    logic [1:0] evt_host_o, evt_type_o;
    logic evt_ready_i = 1'b0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fix_session_tracker dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .hb_interval_i(hb_interval_i),
        .open_i(open_i), .open_host_i(open_host_i), .close_i(close_i), .close_host_i(close_host_i),
        .rx_valid_i(rx_valid_i), .rx_host_i(rx_host_i), .rx_seq_i(rx_seq_i),
        .rx_posdup_i(rx_posdup_i), .rx_gapfill_i(rx_gapfill_i),
        .rx_done_o(rx_done_o), .rx_code_o(rx_code_o), .rx_expected_o(rx_expected_o),
        .tx_req_i(tx_req_i), .tx_host_i(tx_host_i), .tx_ack_o(tx_ack_o), .tx_seq_o(tx_seq_o),
        .evt_valid_o(evt_valid_o), .evt_host_o(evt_host_o), .evt_type_o(evt_type_o),
        .evt_ready_i(evt_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic op(input logic [1:0] h);
        open_i = 1'b1;
        open_host_i = h;
        cyc();
        open_i = 1'b0;
    endtask

    task automatic tk();
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
    endtask

    task automatic rx(input string tag, input logic [1:0] h, input logic [15:0] s, input logic pd,
                      input logic gf, input logic [2:0] code, input logic [15:0] ex);
        rx_valid_i = 1'b1;
        rx_host_i = h;
        rx_seq_i = s;
        rx_posdup_i = pd;
        rx_gapfill_i = gf;
        cyc();
        rx_valid_i = 1'b0;
        rx_posdup_i = 1'b0;
        rx_gapfill_i = 1'b0;
        check({tag, " done"}, 32'(rx_done_o), 1);
        check({tag, " code"}, 32'(rx_code_o), 32'(code));
        check({tag, " expected"}, 32'(rx_expected_o), 32'(ex));
    endtask

    task automatic tx(input string tag, input logic [1:0] h, input logic [15:0] s);
        tx_req_i = 1'b1;
        tx_host_i = h;
        cyc();
        tx_req_i = 1'b0;
        check({tag, " ack"}, 32'(tx_ack_o), 1);
        check({tag, " seq"}, 32'(tx_seq_o), 32'(s));
    endtask

    task automatic ev(input string tag, input logic v, input logic [1:0] h, input logic [1:0] t);
        check({tag, " valid"}, 32'(evt_valid_o), 32'(v));
        if (v) begin
            check({tag, " host"}, 32'(evt_host_o), 32'(h));
            check({tag, " type"}, 32'(evt_type_o), 32'(t));
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, " rx_done"}, 32'(rx_done_o), 0);
        check({tag, " rx_code"}, 32'(rx_code_o), 0);
        check({tag, " rx_expected"}, 32'(rx_expected_o), 0);
        check({tag, " tx_ack"}, 32'(tx_ack_o), 0);
        check({tag, " tx_seq"}, 32'(tx_seq_o), 0);
        check({tag, " evt_valid"}, 32'(evt_valid_o), 0);
        check({tag, " evt_host"}, 32'(evt_host_o), 0);
        check({tag, " evt_type"}, 32'(evt_type_o), 0);
    endtask

    initial begin
        do_reset();
        all_zero("reset");

        // sequence checks on host 1, timers off
        op(1);
        rx("rx1", 1, 1, 0, 0, 0, 1);
        rx("rx2", 1, 2, 0, 0, 0, 2);
        rx("rx3", 1, 3, 0, 0, 0, 3);
        rx("gap", 1, 7, 0, 0, 1, 4);
        rx("dup", 1, 2, 1, 0, 2, 4);
        rx("low", 1, 2, 0, 0, 3, 4);
        rx("gapfill", 1, 10, 0, 1, 0, 4);
        rx("after_gf", 1, 10, 0, 0, 0, 10);
        rx("gf_low", 1, 5, 0, 1, 3, 11);
        rx("idle_host", 3, 1, 0, 0, 4, 0);
        tx("tx_a", 1, 1);
        tx("tx_b", 1, 2);
        tx("tx_idle", 3, 0);

        // close wins over open in the same cycle
        do_reset();
        open_i = 1'b1;
        close_i = 1'b1;
        open_host_i = 1;
        close_host_i = 1;
        cyc();
        open_i = 1'b0;
        close_i = 1'b0;
        tx("close_wins", 1, 0);

        // heartbeat / test request / timeout on host 0
        do_reset();
        hb_interval_i = 3;
        evt_ready_i = 1'b1;
        op(0);
        tk();
        tk();
        ev("tick2", 0, 0, 0);
        tk();
        ev("tick3_tr", 1, 0, 2);
        cyc();
        ev("tick3_hb", 1, 0, 1);
        cyc();
        ev("drained", 0, 0, 0);
        tk();
        tk();
        ev("tick5", 0, 0, 0);
        tk();
        ev("tick6_to", 1, 0, 3);
        cyc();
        ev("tick6_hb", 1, 0, 1);
        tx("tx_timedout", 0, 0);
        rx("rx_timedout", 0, 1, 0, 0, 4, 1);

        // close + rx + tick + tx on host 2 in one cycle
        do_reset();
        hb_interval_i = 1;
        op(2);
        close_i = 1'b1;
        close_host_i = 2;
        tick_i = 1'b1;
        tx_req_i = 1'b1;
        tx_host_i = 2;
        rx("conflict", 2, 1, 0, 0, 4, 1);
        close_i = 1'b0;
        tick_i = 1'b0;
        tx_req_i = 1'b0;
        check("conflict tx_seq", 32'(tx_seq_o), 0);
        ev("conflict evt0", 0, 0, 0);
        cyc();
        ev("conflict evt1", 0, 0, 0);

        // closing a host whose event is presented withdraws it
        evt_ready_i = 1'b0;
        op(2);
        tk();
        ev("present", 1, 2, 2);
        close_i = 1'b1;
        close_host_i = 2;
        cyc();
        close_i = 1'b0;
        ev("dropped", 0, 0, 0);

        // reset while an event is presented
        op(2);
        tk();
        ev("pre_rst", 1, 2, 2);
        rst = 1'b1;
        cyc();
        all_zero("mid_rst");
        rst = 1'b0;
        cyc();
        ev("post_rst", 0, 0, 0);

        // round-robin with all four hosts holding a heartbeat
        do_reset();
        hb_interval_i = 2;
        evt_ready_i = 1'b0;
        for (int h = 0; h < 4; h++) op(2'(h));
        tk();
        for (int h = 0; h < 4; h++) rx("rr_rx", 2'(h), 1, 0, 0, 0, 1);
        tk();
        ev("rr_first", 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            ev("rr_hold", 1, 0, 1);
        end
        evt_ready_i = 1'b1;
        for (int h = 1; h < 4; h++) begin
            cyc();
            ev("rr_next", 1, 2'(h), 1);
        end
        cyc();
        ev("rr_done", 0, 0, 0);

        // outgoing sequence wraps from 0xFFFF to 1
        do_reset();
        hb_interval_i = 0;
        op(2);
        tx_req_i = 1'b1;
        tx_host_i = 2;
        cyc();
        check("wrap first", 32'(tx_seq_o), 1);
        repeat (65533) cyc();
        cyc();
        check("wrap ffff", 32'(tx_seq_o), 32'hFFFF);
        cyc();
        check("wrap one", 32'(tx_seq_o), 1);
        tx_req_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fix_session_tracker.md
# fix_session_tracker

Parametrised per-host FIX session tracker. It generalises the single-counter sequence generator and the tied-off timeout input of the acceptor engine to 2**HOST_ADDR_WIDTH concurrent sessions. It keeps, for each host, the session state, the expected incoming and next outgoing MsgSeqNum, and heartbeat/test-request idle timers. It sits between the received-message processor, the session manager and message creation, and emits arbitrated heartbeat, test-request and timeout events.

## Interface
Parameters:
- HOST_ADDR_WIDTH, 2, host index width; N_HOST = 2**HOST_ADDR_WIDTH
- SEQ_WIDTH, 16, sequence-number width
- HB_WIDTH, 8, idle-timer and interval width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- tick_i  in  1  one-cycle time-base pulse (one heartbeat unit)
- hb_interval_i  in  HB_WIDTH  heartbeat interval in ticks; 0 disables all timers
- open_i / open_host_i  in  1 / HOST_ADDR_WIDTH  logon accepted for host
- close_i / close_host_i  in  1 / HOST_ADDR_WIDTH  session ended for host
- rx_valid_i, rx_host_i, rx_seq_i, rx_posdup_i, rx_gapfill_i  in  1, HOST_ADDR_WIDTH, SEQ_WIDTH, 1, 1  incoming message header; for gap fill, rx_seq_i carries NewSeqNo
- rx_done_o, rx_code_o, rx_expected_o  out  1, 3, SEQ_WIDTH  check result and the expected number *before* the update
- tx_req_i / tx_host_i  in  1 / HOST_ADDR_WIDTH  request an outgoing sequence number
- tx_ack_o / tx_seq_o  out  1 / SEQ_WIDTH  granted number
- evt_valid_o, evt_host_o, evt_type_o  out  1, HOST_ADDR_WIDTH, 2  event; type codes: 1 = HEARTBEAT, 2 = TESTREQ, 3 = TIMEOUT
- evt_ready_i  in  1  event consumer handshake

## Operation
Per-host state machine:
- States: IDLE, ACTIVE, TESTREQ_SENT.
- open → ACTIVE from any state. On open: expected = 1, next_tx = 1, both timers = 0, pending flags cleared.
- close → IDLE from any state. On close: pending flags cleared.
- ACTIVE → TESTREQ_SENT when rx_idle reaches hb_interval. Set the TESTREQ pending flag and clear rx_idle.
- TESTREQ_SENT → IDLE when rx_idle reaches hb_interval again. Set the TIMEOUT pending flag.
- Any rx_valid_i on an ACTIVE or TESTREQ_SENT host clears rx_idle and returns TESTREQ_SENT to ACTIVE.

Rx check (host not IDLE):
- seq == expected: OK (0); expected += 1.
- seq > expected: GAP (1); expected unchanged.
- seq < expected with posdup: DUP (2); ignored.
- seq < expected without posdup: LOW (3); fatal. The session manager closes the session.
- gapfill with NewSeqNo ≥ expected: OK; expected = NewSeqNo. Gapfill with NewSeqNo < expected: LOW.
- Host IDLE: NOT_ACTIVE (4); no state change.

Tx:
- tx_seq_o = next_tx; next_tx += 1; tx_idle cleared.
- On a host that is not ACTIVE, tx_ack_o still pulses and tx_seq_o = 0; no update.

Timers (host not IDLE, hb_interval ≠ 0):
- Every tick increments rx_idle and tx_idle.
- tx_idle reaching hb_interval sets the HEARTBEAT pending flag and clears tx_idle.

Arithmetic:
- Sequence numbers wrap from all-ones to 1, never to 0.
- Timers saturate at all-ones.
- The ≥ comparison is used, so lowering hb_interval at runtime fires on the next tick.

Events:
- Round-robin over hosts, starting after the last granted host.
- Within a host, priority is TIMEOUT > TESTREQ > HEARTBEAT.
- The granted flag clears on evt_valid_o & evt_ready_i.

## Timing
- All outputs are registered. Reset values: rx_done_o = 0, rx_code_o = 0, rx_expected_o = 0, tx_ack_o = 0, tx_seq_o = 0, evt_valid_o = 0, evt_host_o = 0, evt_type_o = 0.
- Reset also sets all hosts to IDLE, counters to 0, RR pointer to 0. Reset mid-operation discards pending events.
- rx_done_o and tx_ack_o follow their request by exactly 1 cycle. One rx and one tx may be accepted every cycle, including on the same host.
- Same-cycle conflicts on one host, highest priority first:
  1. open/close override rx, tx and tick. rx then reports NOT_ACTIVE if close or open won; tx gets seq 0.
  2. close wins over open.
  3. rx or tx clearing a timer wins over a tick increment.
- A newly set pending flag may appear on evt_valid_o 1 cycle later at the earliest.
- Events follow valid/ready rules: evt_valid_o, evt_host_o and evt_type_o are held stable until accepted. The next event may issue in the cycle after acceptance.
- A pending flag set again while it is still pending merges into a single event.
- Closing a host whose event is currently presented drops that event: evt_valid_o deasserts the next cycle.

## Structure
- Package fix_session_pkg holds:
  - state_t {IDLE, ACTIVE, TESTREQ_SENT}
  - rx_code_t {OK, GAP, DUP, LOW, NOT_ACTIVE}
  - evt_t {NONE, HEARTBEAT, TESTREQ, TIMEOUT}
- Per-host fields are register arrays indexed by host. Timers update in parallel on each tick.
- One sub-module: fix_event_arbiter. It takes N_HOST × 3 pending flags and owns the round-robin pointer, the priority encode, and the valid/ready output register.

## Test plan
- Open host 1, send rx seq 1, 2, 3 → codes OK, OK, OK; rx_expected_o = 1, 2, 3; then rx seq 7 → GAP with expected 4.
- Host 1 at expected 4: rx seq 2 with posdup → DUP; rx seq 2 without posdup → LOW; gapfill NewSeqNo 10 → OK, next check expects 10.
- hb_interval = 3, host 0 open, no traffic, evt_ready_i = 1 → HEARTBEAT and TESTREQ on tick 3; TIMEOUT on tick 6; host 0 then IDLE and tx_seq_o = 0.
- Hosts 0–3 all get HEARTBEAT pending in the same cycle, evt_ready_i held low 5 cycles then high → event held stable, then hosts granted 0, 1, 2, 3 on consecutive cycles.
- next_tx forced to 0xFFFF (SEQ_WIDTH = 16) → two tx requests return 0xFFFF then 0x0001.
- Same cycle: close host 2 + rx host 2 + tick → rx reports NOT_ACTIVE; no event for host 2. Assert rst mid-event → all outputs 0 in the next cycle.
